// File: rtl/ula_pkg.sv
// Shared types and default widths for the ULA flag generator.
package ula_pkg;

  localparam int ULA_IN_WIDTH  = 8;
  localparam int ULA_OUT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ula_fg_state_t;

endpackage

// File: rtl/ula_serial_fa.sv
// One-bit full adder cell reused on every cycle of the serial subtraction.
module ula_serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ula_flag_gen.sv
// Bit-serial A - B with registered zero/sign/carry/overflow flags and a
// sign-extended difference, framed by valid/ready handshakes on both sides.
module ula_flag_gen
  import ula_pkg::*;
#(
  parameter int WIDTH     = ULA_IN_WIDTH,
  parameter int OUT_WIDTH = ULA_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 zero_flag,
  output logic                 sign_flag,
  output logic                 carry_flag,
  output logic                 overflow_flag
);

  ula_fg_state_t    state_r;
  ula_fg_state_t    state_nx_s;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] diff_r;
  logic             carry_r;
  logic             zacc_r;

  logic             sum_s;
  logic             cout_s;
  logic             last_s;
  logic             ovf_s;
  logic             sign_s;
  logic [WIDTH-1:0] diff_full_s;

  ula_serial_fa u_fa (
    .a   (a_sh_r[0]),
    .b   (b_sh_r[0]),
    .cin (carry_r),
    .sum (sum_s),
    .cout(cout_s)
  );

  // The final sum bit completes the difference; carry_r is then the carry into the MSB.
  assign last_s      = (state_r == RUN) && (cnt_r == 4'(WIDTH - 1));
  assign diff_full_s = {sum_s, diff_r};
  assign ovf_s       = carry_r ^ cout_s;
  assign sign_s      = sum_s ^ ovf_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Serial datapath, handshake outputs and flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      cnt_r         <= 4'd0;
      a_sh_r        <= '0;
      b_sh_r        <= '0;
      diff_r        <= '0;
      carry_r       <= 1'b0;
      zacc_r        <= 1'b0;
      result        <= '0;
      zero_flag     <= 1'b0;
      sign_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      in_ready  <= (state_nx_s == IDLE);
      out_valid <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= ~b;
            carry_r <= 1'b1;
            cnt_r   <= 4'd0;
            zacc_r  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r  <= a_sh_r >> 1;
          b_sh_r  <= b_sh_r >> 1;
          diff_r  <= diff_full_s[WIDTH-1:1];
          zacc_r  <= zacc_r | sum_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + 4'd1;
          if (last_s) begin
            zero_flag     <= ~(zacc_r | sum_s);
            carry_flag    <= cout_s;
            overflow_flag <= ovf_s;
            sign_flag     <= sign_s;
            result        <= {{(OUT_WIDTH - WIDTH){sign_s}}, diff_full_s};
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_flag_gen.sv
// Randomised and directed bench for ula_flag_gen against an arithmetic reference model.
module tb_ula_flag_gen;

  localparam int W  = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid;
  logic [OW-1:0] result;
  logic          zero_flag, sign_flag, carry_flag, overflow_flag;

  int total = 0;
  int bad   = 0;

  ula_flag_gen #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .carry_flag(carry_flag), .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic void ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [OW-1:0] r, output logic z,
                                   output logic s, output logic c, output logic v);
    int sx, sy, d;
    sx = (x >= 8'h80) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'h80) ? int'(y) - 256 : int'(y);
    d  = sx - sy;
    r  = OW'(d);
    z  = (x == y);
    s  = (d < 0);
    c  = (int'(x) >= int'(y));
    v  = (d > 127) || (d < -128);
  endfunction

  // Transaction-level timing model: busy for W cycles, then result held until taken.
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (m_ready) begin
      if (in_valid) begin
        m_ready <= 1'b0;
        m_left  <= W;
        m_a     <= a;
        m_b     <= b;
      end
    end else if (!m_valid) begin
      if (m_left == 1) m_valid <= 1'b1;
      m_left <= m_left - 1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    logic [OW-1:0] er;
    logic ez, es, ec, ev;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        ref_calc(m_a, m_b, er, ez, es, ec, ev);
        chk("result", 32'(result), 32'(er));
        chk("zero", 32'(zero_flag), 32'(ez));
        chk("sign", 32'(sign_flag), 32'(es));
        chk("carry", 32'(carry_flag), 32'(ec));
        chk("ovf", 32'(overflow_flag), 32'(ev));
      end
    end
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic [OW-1:0] r,
                          input logic z, input logic s, input logic c, input logic v);
    logic [OW-1:0] mr;
    logic mz, ms, mc, mv;
    int cyc;
    ref_calc(x, y, mr, mz, ms, mc, mv);
    chk("model_flags", {27'd0, mr == r, mz, ms, mc, mv}, {27'd0, 1'b1, z, s, c, v});
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("latency", 32'(cyc), 32'd8);
    chk("lit_result", 32'(result), 32'(r));
    chk("lit_flags", {28'd0, zero_flag, sign_flag, carry_flag, overflow_flag},
                     {28'd0, z, s, c, v});
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {28'd0, zero_flag, sign_flag, carry_flag, overflow_flag}, 32'd0);
    #2 rst = 1'b0;

    directed(8'h05, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed(8'h03, 8'h07, 16'hFFFC, 1'b0, 1'b1, 1'b0, 1'b0);
    directed(8'h80, 8'h01, 16'hFF7F, 1'b0, 1'b1, 1'b1, 1'b1);
    directed(8'h7F, 8'hFF, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure with an ignored second offer.
    @(negedge clk);
    a = 8'h03; b = 8'h07; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      a = 8'h11; b = 8'h22; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h0000FFFC);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of RUN.
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_flags", {28'd0, zero_flag, sign_flag, carry_flag, overflow_flag}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    directed(8'h80, 8'h01, 16'hFF7F, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      a         = W'($urandom);
      b         = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a = 8'h80;
      if ($urandom_range(0, 9) == 0) b = 8'h7F;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_flag_gen.md
# ula_flag_gen

Sequential flag generator for the 8-bit-in / 16-bit-out ULA. It takes two operands, performs a bit-serial subtraction A − B one bit per clock, and produces the condition flags (zero, sign, carry, overflow) and a 16-bit sign-extended difference. The comparison block downstream consumes these flags. Valid/ready handshakes on both input and output let the ULA sequencer stall either side.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≤ 15.
- `OUT_WIDTH`, default 16: result width in bits; must be > WIDTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  operands present on `a`/`b`.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend, two's complement.
- `b`  in  WIDTH  subtrahend, two's complement.
- `out_valid`  out  1  flags and result valid; high only in DONE.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  OUT_WIDTH  true signed A − B, sign-extended.
- `zero_flag`  out  1  A == B.
- `sign_flag`  out  1  A < B, signed (N xor V).
- `carry_flag`  out  1  no borrow: A ≥ B, unsigned.
- `overflow_flag`  out  1  WIDTH-bit signed subtraction overflowed.

## Operation
- FSM states: IDLE, RUN, DONE. `rst` forces IDLE.
- IDLE: `in_ready`=1. When `in_valid` is high, the block latches `a` and `~b` into shift registers. It sets carry=1, bit counter=0, and zero accumulator=0, then goes to RUN.
- RUN: each cycle the full-adder cell adds the LSBs of both shift registers and the carry. The sum bit shifts into the diff register from the MSB side; both operand registers shift right. The block ORs the sum into the zero accumulator, updates carry, and increments the counter.
- On the cycle the counter reaches WIDTH−1, the block moves to DONE and registers the flags:
  - `zero_flag` = ~(accumulator | last sum bit).
  - `carry_flag` = final carry out.
  - `overflow_flag` = carry into MSB xor carry out.
  - `sign_flag` = MSB of diff xor `overflow_flag`.
  - `result`: the true difference uses WIDTH+1 bits: {`sign_flag`, diff}. It is sign-extended with `sign_flag` to OUT_WIDTH.
- DONE: `out_valid`=1. Outputs hold stable until `out_ready`=1, then the block returns to IDLE.
- `in_valid` outside IDLE is ignored; the operands are not sampled.
- Flag and result registers keep their last values in IDLE/RUN. Consumers must qualify them with `out_valid`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, all four flags 0; counter and shift registers are 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. Outputs take their reset values immediately (asynchronous). The first accept is possible on the first rising edge after `rst` deasserts.
- Latency: operands are accepted at edge k. `out_valid` rises after edge k+WIDTH (8 cycles with the default WIDTH).
- Throughput: one operation per WIDTH+2 cycles with `out_ready` held high. There is no accept in the same cycle as the DONE→IDLE handoff.
- Back-pressure: DONE persists indefinitely while `out_ready`=0, and `in_ready` stays 0.

## Structure
- Package `ula_pkg` holds:
  - the `ula_fg_state_t` enum (IDLE, RUN, DONE);
  - the constants `ULA_IN_WIDTH`=8 and `ULA_OUT_WIDTH`=16, which supply the parameter defaults.
- Sub-module `ula_serial_fa` is a 1-bit full adder (a, b, cin → sum, cout). It is instantiated once and reused every RUN cycle.
- The top level holds the FSM, counter, shift registers, zero accumulator and flag registers.

## Test plan
- a=0x05, b=0x05, accept at edge k → `out_valid` after edge k+8; `result`=0x0000, zero=1, sign=0, carry=1, ovf=0.
- a=0x03, b=0x07 → `result`=0xFFFC, zero=0, sign=1, carry=0, ovf=0.
- a=0x80, b=0x01 → `result`=0xFF7F (−129), sign=1, ovf=1, carry=1, zero=0.
- a=0x7F, b=0xFF → `result`=0x0080 (+128), sign=0, ovf=1, carry=0, zero=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE and pulse `in_valid` with new operands → outputs stable, `in_ready`=0, new operands not captured. Release `out_ready` → IDLE next cycle.
- Assert `rst` at RUN cycle 4 → `out_valid`=0, `in_ready`=1, flags 0 immediately. The next operation then yields correct results.
